// File: rtl/irq_pkg.sv
// Shared types and defaults for the vectored priority interrupt controller.
package irq_pkg;

   localparam int unsigned IRQ_N_DEF   = 8;
   localparam logic [7:0]  IRQ_VEC_DEF = 8'hF8;
   localparam int unsigned IRQ_LVL_W   = $clog2(IRQ_N_DEF);

   // One-hot controller states
   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_ARMED = 3'b010,
      S_GRANT = 3'b100
   } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-set-bit encoder: index of the most significant set bit plus an any flag.
module irq_prio_enc #(
   parameter  int unsigned W  = 8,
   localparam int unsigned IW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);

   // Ascending scan so the last hit is the highest set bit
   always_comb begin
      idx_c = '0;
      any_c = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         if (vec[i]) begin
            idx_c = IW'(i);
            any_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Vectored priority interrupt controller for the stage-0 fetch/branch unit.
// Define IRQ_NEST_EN to allow a higher level to preempt an in-service level.
module irq_priority_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned N_IRQ    = IRQ_N_DEF,
   parameter logic [7:0]  VEC_BASE = IRQ_VEC_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [N_IRQ-1:0] irq_req,
   input  logic             mask_ld,
   input  logic [N_IRQ-1:0] mask_data,
   input  logic             i_ack,
   input  logic             i_ret,
   output logic             i_pending,
   output logic [7:0]       vec_out,
   output logic             vec_valid,
   output logic [N_IRQ-1:0] isr_out,
   output logic [N_IRQ-1:0] mask_out
);

   localparam int unsigned LW = $clog2(N_IRQ);

   irq_state_t       state;
   logic [N_IRQ-1:0] prev;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] above;
   logic [N_IRQ-1:0] elig;
   logic [N_IRQ-1:0] win_oh;
   logic [N_IRQ-1:0] ret_oh;
   logic [LW-1:0]    win;
   logic [LW-1:0]    isr_top;
   logic             win_any;
   logic             isr_any;
   logic             grant;

   irq_prio_enc #(.W(N_IRQ)) u_win_enc (
      .vec   (elig),
      .idx_c (win),
      .any_c (win_any)
   );

   irq_prio_enc #(.W(N_IRQ)) u_isr_enc (
      .vec   (isr_out),
      .idx_c (isr_top),
      .any_c (isr_any)
   );

   // Levels allowed to interrupt given what is already in service
   always_comb begin
      above = '1;
      if (isr_any) begin
`ifdef IRQ_NEST_EN
         for (int i = 0; i < int'(N_IRQ); i++) begin
            above[i] = (i > int'(isr_top));
         end
`else
         above = '0;
`endif
      end
   end

   assign rise   = irq_req & ~prev;
   assign elig   = pending & mask_out & above;
   assign win_oh = N_IRQ'(1) << win;
   assign ret_oh = (i_ret && isr_any) ? (N_IRQ'(1) << isr_top) : '0;
   assign grant  = (state == S_ARMED) && win_any && i_ack && !i_ret;

   // Request capture, mask, in-service tracking and the offer/grant sequencer
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_IDLE;
         prev      <= '0;
         pending   <= '0;
         isr_out   <= '0;
         mask_out  <= '0;
         i_pending <= 1'b0;
         vec_out   <= 8'h00;
         vec_valid <= 1'b0;
      end else begin
         prev      <= irq_req;
         // A grant clears its bit first; a fresh edge on the same line survives
         pending   <= (pending & ~(grant ? win_oh : '0)) | rise;
         isr_out   <= (isr_out & ~ret_oh) | (grant ? win_oh : '0);
         vec_valid <= 1'b0;
         if (mask_ld) begin
            mask_out <= mask_data;
         end

         case (state)
            S_IDLE: begin
               if (win_any) begin
                  vec_out   <= VEC_BASE + 8'(win);
                  i_pending <= 1'b1;
                  state     <= S_ARMED;
               end else begin
                  i_pending <= 1'b0;
               end
            end
            S_ARMED: begin
               if (!win_any) begin
                  i_pending <= 1'b0;
                  state     <= S_IDLE;
               end else if (grant) begin
                  vec_out   <= VEC_BASE + 8'(win);
                  i_pending <= 1'b0;
                  vec_valid <= 1'b1;
                  state     <= S_GRANT;
               end else begin
                  vec_out   <= VEC_BASE + 8'(win);
                  i_pending <= 1'b1;
               end
            end
            S_GRANT: begin
               i_pending <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               i_pending <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed plus random bench for irq_priority_ctrl against a behavioural model.
// Honours IRQ_NEST_EN the same way as the design.
module tb_irq_priority_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] irq_req;
   logic       mask_ld;
   logic [7:0] mask_data;
   logic       i_ack;
   logic       i_ret;
   logic       i_pending;
   logic [7:0] vec_out;
   logic       vec_valid;
   logic [7:0] isr_out;
   logic [7:0] mask_out;

   int total = 0;
   int bad   = 0;

   irq_priority_ctrl dut (
      .clk       (clk),
      .clr       (clr),
      .irq_req   (irq_req),
      .mask_ld   (mask_ld),
      .mask_data (mask_data),
      .i_ack     (i_ack),
      .i_ret     (i_ret),
      .i_pending (i_pending),
      .vec_out   (vec_out),
      .vec_valid (vec_valid),
      .isr_out   (isr_out),
      .mask_out  (mask_out)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit [7:0] m_prev, m_pend, m_mask, m_isr, m_vec;
   bit       m_ip, m_vv;
   bit       m_offering, m_granting;

   function automatic int top_bit(input bit [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit [7:0] allowed(input bit [7:0] isr);
      bit [7:0] r;
      int h;
      h = top_bit(isr);
      if (h < 0) return 8'hFF;
      r = 8'h00;
`ifdef IRQ_NEST_EN
      for (int i = 0; i < 8; i++) if (i > h) r[i] = 1'b1;
`endif
      return r;
   endfunction

   task automatic model_step(input bit [7:0] req, input bit ld, input bit [7:0] md,
                             input bit ack, input bit ret, input bit c);
      bit [7:0] elig, npend, nisr;
      int w;
      if (c) begin
         m_prev = 0; m_pend = 0; m_mask = 0; m_isr = 0; m_vec = 0;
         m_ip = 0; m_vv = 0; m_offering = 0; m_granting = 0;
         return;
      end
      elig  = m_pend & m_mask & allowed(m_isr);
      w     = top_bit(elig);
      npend = m_pend;
      nisr  = m_isr;
      if (ret && m_isr != 0) nisr[top_bit(m_isr)] = 1'b0;
      m_vv = 0;
      if (m_granting) begin
         m_granting = 0;
         m_ip = 0;
      end else if (!m_offering) begin
         if (w >= 0) begin
            m_vec = 8'hF8 + 8'(w); m_ip = 1; m_offering = 1;
         end else m_ip = 0;
      end else begin
         if (w < 0) begin
            m_ip = 0; m_offering = 0;
         end else if (ack && !ret) begin
            npend[w] = 1'b0; nisr[w] = 1'b1;
            m_vec = 8'hF8 + 8'(w); m_ip = 0; m_vv = 1;
            m_offering = 0; m_granting = 1;
         end else begin
            m_vec = 8'hF8 + 8'(w); m_ip = 1;
         end
      end
      m_pend = npend | (req & ~m_prev);
      m_isr  = nisr;
      m_prev = req;
      if (ld) m_mask = md;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit [7:0] req, input bit ld, input bit [7:0] md,
                       input bit ack, input bit ret, input bit c);
      @(negedge clk);
      irq_req = req; mask_ld = ld; mask_data = md;
      i_ack = ack; i_ret = ret; clr = c;
      model_step(req, ld, md, ack, ret, c);
      @(posedge clk);
      #1;
      chk("i_pending", 32'(i_pending), 32'(m_ip));
      chk("vec_out",   32'(vec_out),   32'(m_vec));
      chk("vec_valid", 32'(vec_valid), 32'(m_vv));
      chk("isr_out",   32'(isr_out),   32'(m_isr));
      chk("mask_out",  32'(mask_out),  32'(m_mask));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'h00, 0, 8'h00, 0, 0, 0);
   endtask

   initial begin
      clr = 1'b1; irq_req = 0; mask_ld = 0; mask_data = 0; i_ack = 0; i_ret = 0;

      // Reset and basic offer/grant on level 3
      step(8'h00, 0, 8'h00, 0, 0, 1);
      chk("rst_vec", 32'(vec_out), 32'h00);
      chk("rst_ipend", 32'(i_pending), 32'h0);
      step(8'h00, 1, 8'hFF, 0, 0, 0);
      step(8'h08, 0, 8'h00, 0, 0, 0);
      chk("tp1_not_yet", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 0, 0, 0);
      chk("tp1_ipend", 32'(i_pending), 32'h1);
      chk("tp1_vec", 32'(vec_out), 32'hFB);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp1_vv", 32'(vec_valid), 32'h1);
      chk("tp1_isr", 32'(isr_out), 32'h08);
      chk("tp1_ipend0", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp1_vv_pulse", 32'(vec_valid), 32'h0);
      step(8'h00, 0, 8'h00, 0, 1, 0);
      chk("tp1_rti", 32'(isr_out), 32'h00);

      // Masked request is held, then released by a new mask
      step(8'h00, 1, 8'h00, 0, 0, 0);
      step(8'h20, 0, 8'h00, 0, 0, 0);
      idle(3);
      chk("tp2_masked", 32'(i_pending), 32'h0);
      step(8'h00, 1, 8'h20, 0, 0, 0);
      step(8'h00, 0, 8'h00, 0, 0, 0);
      chk("tp2_ipend", 32'(i_pending), 32'h1);
      chk("tp2_vec", 32'(vec_out), 32'hFD);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 0, 1, 0);

      // Two simultaneous levels: highest wins, lower re-offered after RTI
      step(8'h00, 1, 8'hFF, 0, 0, 0);
      step(8'h44, 0, 8'h00, 0, 0, 0);
      idle(1);
      chk("tp3_vec", 32'(vec_out), 32'hFE);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp3_isr", 32'(isr_out), 32'h40);
      idle(2);
      chk("tp3_held", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 0, 1, 0);
      chk("tp3_isr0", 32'(isr_out), 32'h00);
      step(8'h00, 0, 8'h00, 0, 0, 0);
      chk("tp3_reoffer", 32'(i_pending), 32'h1);
      chk("tp3_vec2", 32'(vec_out), 32'hFA);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 0, 1, 0);

      // Nesting: level 4 in service, level 7 arrives
      step(8'h10, 0, 8'h00, 0, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp4_isr", 32'(isr_out), 32'h10);
      idle(1);
      step(8'h80, 0, 8'h00, 0, 0, 0);
      idle(1);
`ifdef IRQ_NEST_EN
      chk("tp4_nest_offer", 32'(i_pending), 32'h1);
      chk("tp4_nest_vec", 32'(vec_out), 32'hFF);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp4_nest_isr", 32'(isr_out), 32'h90);
      idle(1);
      step(8'h02, 0, 8'h00, 0, 0, 0);
      idle(2);
      chk("tp4_lvl1_blocked", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 0, 1, 0);
      idle(2);
      chk("tp4_lvl1_still", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 0, 1, 0);
      idle(1);
      chk("tp4_lvl1_offer", 32'(vec_out), 32'hF9);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 0, 1, 0);
`else
      chk("tp4_flat_block", 32'(i_pending), 32'h0);
      step(8'h00, 0, 8'h00, 0, 1, 0);
      idle(1);
      chk("tp4_flat_offer", 32'(vec_out), 32'hFF);
      step(8'h00, 0, 8'h00, 1, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 0, 1, 0);
`endif
      idle(2);

      // Ack and RTI in the same ARMED cycle: ack dropped
      step(8'h20, 0, 8'h00, 0, 0, 0);
      idle(1);
      step(8'h00, 0, 8'h00, 1, 1, 0);
      chk("tp5_ipend", 32'(i_pending), 32'h1);
      chk("tp5_vv", 32'(vec_valid), 32'h0);
      chk("tp5_vec", 32'(vec_out), 32'hFD);

      // Reset during GRANT
      step(8'h00, 0, 8'h00, 1, 0, 0);
      chk("tp6_grant", 32'(vec_valid), 32'h1);
      step(8'hFF, 0, 8'h00, 1, 1, 1);
      chk("tp6_vec", 32'(vec_out), 32'h00);
      chk("tp6_vv", 32'(vec_valid), 32'h0);
      chk("tp6_isr", 32'(isr_out), 32'h00);
      chk("tp6_mask", 32'(mask_out), 32'h00);
      step(8'h00, 0, 8'h00, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit [7:0] r;
         bit ld, ak, rt, c;
         r  = 8'($urandom) & 8'($urandom);
         ld = ($urandom_range(0, 15) == 0);
         ak = ($urandom_range(0, 2) == 0);
         rt = ($urandom_range(0, 5) == 0);
         c  = ($urandom_range(0, 199) == 0);
         step(r, ld, 8'($urandom), ak, rt, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
